// File: rtl/alu_rs.sv
// ALU reservation station.
// Holds up to RS_SIZE waiting ALU instructions. Operation alternates between
// two phases chosen by update_stat:
//   accept phase : take one new instruction and apply a CDB result broadcast
//   issue phase  : send the lowest-index fully-ready entry to the ALU
// All activity is gated by chip_enable, a registered copy of rdy.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int IQ_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 update_stat,
    input  logic                 clear_flag_in,
    output logic                 full_out,
    input  logic                 dispatch_enable_in,
    input  logic [3:0]           dispatch_calc_code_in,
    input  logic                 dispatch_lhs_ready_in,
    input  logic                 dispatch_rhs_ready_in,
    input  logic [31:0]          dispatch_lhs_in,
    input  logic [31:0]          dispatch_rhs_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_lhs_tag_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_rhs_tag_in,
    input  logic [IQ_ADDR_W-1:0] dispatch_pos_in_iq_in,
    input  logic                 cdb_enable_in,
    input  logic [IQ_ADDR_W-1:0] cdb_idx_in,
    input  logic [31:0]          cdb_result_in,
    input  logic                 alu_full_in,
    output logic                 calc_enable_out,
    output logic [3:0]           calc_code_out,
    output logic [31:0]          lhs_out,
    output logic [31:0]          rhs_out,
    output logic [IQ_ADDR_W-1:0] pos_in_iq_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Registered copy of rdy; when low every other register holds.
    logic r_chip_enable;

    // Output registers
    logic                 r_calc_enable;
    logic [3:0]           r_calc_code;
    logic [31:0]          r_lhs_out;
    logic [31:0]          r_rhs_out;
    logic [IQ_ADDR_W-1:0] r_pos_out;

    // Per-entry state gathered from the generate blocks
    logic [RS_SIZE-1:0]   w_valid;
    logic [RS_SIZE-1:0]   w_ready;
    logic [3:0]           w_code [RS_SIZE];
    logic [31:0]          w_lhs  [RS_SIZE];
    logic [31:0]          w_rhs  [RS_SIZE];
    logic [IQ_ADDR_W-1:0] w_pos  [RS_SIZE];

    // Phase qualifiers and selections
    logic                 w_accept;
    logic                 w_issue_phase;
    logic                 w_dispatch_go;
    logic                 w_issue_go;
    logic                 w_ready_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic [IDX_W-1:0]     w_issue_idx;

    // Dispatch operands after CDB bypass
    logic                 w_disp_lhs_ready;
    logic                 w_disp_rhs_ready;
    logic [31:0]          w_disp_lhs_val;
    logic [31:0]          w_disp_rhs_val;

    assign full_out = &w_valid;

    // A flush or reset suppresses both phases entirely.
    assign w_accept      = ~rst & r_chip_enable &  update_stat & ~clear_flag_in;
    assign w_issue_phase = ~rst & r_chip_enable & ~update_stat & ~clear_flag_in;
    assign w_dispatch_go = w_accept & dispatch_enable_in & ~full_out;
    assign w_issue_go    = w_issue_phase & ~alu_full_in & w_ready_found;

    // A result broadcast in the same cycle as dispatch is captured directly,
    // otherwise the new entry would miss it and wait forever.
    assign w_disp_lhs_ready = dispatch_lhs_ready_in |
                              (cdb_enable_in & (dispatch_lhs_tag_in == cdb_idx_in));
    assign w_disp_rhs_ready = dispatch_rhs_ready_in |
                              (cdb_enable_in & (dispatch_rhs_tag_in == cdb_idx_in));
    assign w_disp_lhs_val   = dispatch_lhs_ready_in ? dispatch_lhs_in : cdb_result_in;
    assign w_disp_rhs_val   = dispatch_rhs_ready_in ? dispatch_rhs_in : cdb_result_in;

    // Priority scans: lowest free entry for dispatch, lowest ready entry for issue.
    always_comb begin
        w_free_idx    = '0;
        w_issue_idx   = '0;
        w_ready_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_ready_found = 1'b1;
                w_issue_idx   = IDX_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic                 r_valid;
            logic                 r_lhs_ready;
            logic                 r_rhs_ready;
            logic [3:0]           r_code;
            logic [31:0]          r_lhs;
            logic [31:0]          r_rhs;
            logic [IQ_ADDR_W-1:0] r_lhs_tag;
            logic [IQ_ADDR_W-1:0] r_rhs_tag;
            logic [IQ_ADDR_W-1:0] r_pos;
            logic                 w_write;
            logic                 w_take;
            logic                 w_lhs_wake;
            logic                 w_rhs_wake;

            assign w_write    = w_dispatch_go & (w_free_idx == IDX_W'(gi));
            assign w_take     = w_issue_go & (w_issue_idx == IDX_W'(gi));
            assign w_lhs_wake = w_accept & cdb_enable_in & r_valid & ~r_lhs_ready &
                                (r_lhs_tag == cdb_idx_in);
            assign w_rhs_wake = w_accept & cdb_enable_in & r_valid & ~r_rhs_ready &
                                (r_rhs_tag == cdb_idx_in);

            // Occupancy: set on dispatch, cleared on issue, flush or reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                end else if (r_chip_enable) begin
                    if (clear_flag_in) begin
                        r_valid <= 1'b0;
                    end else if (w_write) begin
                        r_valid <= 1'b1;
                    end else if (w_take) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            // Payload: loaded on dispatch, operands filled in by CDB wakeups.
            always_ff @(posedge clk) begin
                if (w_write) begin
                    r_code      <= dispatch_calc_code_in;
                    r_lhs       <= w_disp_lhs_val;
                    r_rhs       <= w_disp_rhs_val;
                    r_lhs_ready <= w_disp_lhs_ready;
                    r_rhs_ready <= w_disp_rhs_ready;
                    r_lhs_tag   <= dispatch_lhs_tag_in;
                    r_rhs_tag   <= dispatch_rhs_tag_in;
                    r_pos       <= dispatch_pos_in_iq_in;
                end else begin
                    if (w_lhs_wake) begin
                        r_lhs       <= cdb_result_in;
                        r_lhs_ready <= 1'b1;
                    end
                    if (w_rhs_wake) begin
                        r_rhs       <= cdb_result_in;
                        r_rhs_ready <= 1'b1;
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_ready[gi] = r_valid & r_lhs_ready & r_rhs_ready;
            assign w_code[gi]  = r_code;
            assign w_lhs[gi]   = r_lhs;
            assign w_rhs[gi]   = r_rhs;
            assign w_pos[gi]   = r_pos;
        end
    endgenerate

    // Issue register: the strobe lives for one edge; accept phase drops it
    // at the same edge the ALU samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chip_enable <= 1'b0;
            r_calc_enable <= 1'b0;
            r_calc_code   <= '0;
            r_lhs_out     <= '0;
            r_rhs_out     <= '0;
            r_pos_out     <= '0;
        end else begin
            r_chip_enable <= rdy;
            if (r_chip_enable) begin
                if (w_issue_go) begin
                    r_calc_enable <= 1'b1;
                    r_calc_code   <= w_code[w_issue_idx];
                    r_lhs_out     <= w_lhs[w_issue_idx];
                    r_rhs_out     <= w_rhs[w_issue_idx];
                    r_pos_out     <= w_pos[w_issue_idx];
                end else begin
                    r_calc_enable <= 1'b0;
                end
            end
        end
    end

    assign calc_enable_out = r_calc_enable;
    assign calc_code_out   = r_calc_code;
    assign lhs_out         = r_lhs_out;
    assign rhs_out         = r_rhs_out;
    assign pos_in_iq_out   = r_pos_out;

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of station entries (power of two, 2..16).
REQ-002 Parameter IQ_ADDR_W, default 4, width of instruction-queue index/tag.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rdy  input  1  global ready; registered into internal chip_enable (chip_enable <= rdy).
REQ-006 update_stat  input  1  phase select: 1 = accept phase, 0 = issue phase.
REQ-007 clear_flag_in  input  1  pipeline flush.
REQ-008 full_out  output  1  all RS_SIZE entries valid (combinational from valid bits).
REQ-009 dispatch_enable_in  input  1  new instruction offered.
REQ-010 dispatch_calc_code_in  input  4  ALU op code 0..15.
REQ-011 dispatch_lhs_ready_in / dispatch_rhs_ready_in  input  1 each  operand value valid.
REQ-012 dispatch_lhs_in / dispatch_rhs_in  input  32 each  operand value when ready.
REQ-013 dispatch_lhs_tag_in / dispatch_rhs_tag_in  input  IQ_ADDR_W each  producer IQ index when not ready.
REQ-014 dispatch_pos_in_iq_in  input  IQ_ADDR_W  IQ slot of this instruction.
REQ-015 cdb_enable_in  input  1  result broadcast valid.
REQ-016 cdb_idx_in  input  IQ_ADDR_W  producer IQ index of broadcast.
REQ-017 cdb_result_in  input  32  broadcast value.
REQ-018 alu_full_in  input  1  ALU holds an unwritten result; no issue allowed.
REQ-019 calc_enable_out  output  1  issue strobe to ALU.
REQ-020 calc_code_out  output  4  issued op code.
REQ-021 lhs_out / rhs_out  output  32 each  issued operand values.
REQ-022 pos_in_iq_out  output  IQ_ADDR_W  issued instruction's IQ slot.

Function
REQ-023 chip_enable low: no state or output change (all registers hold).
REQ-024 Entry state: valid, code, lhs/rhs value, lhs/rhs ready, lhs/rhs tag, pos_in_iq.
REQ-025 Accept phase (update_stat=1, no clear): dispatch_enable_in with full_out low writes lowest-index free entry, valid=1.
REQ-026 Dispatch while full_out high SHALL be dropped; no entry modified.
REQ-027 Accept phase: cdb_enable_in wakes every valid entry whose operand is not ready and tag == cdb_idx_in; value <= cdb_result_in, ready <= 1.
REQ-028 Same-cycle dispatch + matching CDB: the new entry's unready operand captures cdb_result_in and is written ready (bypass); one lhs and rhs both may match.
REQ-029 Accept phase: calc_enable_out SHALL be cleared at the edge; ALU samples the held value 1 at that same edge, so each issue is visible for exactly one accept-phase edge.
REQ-030 Issue phase (update_stat=0, no clear): if alu_full_in low and some valid entry has both operands ready, select lowest index, register code/lhs/rhs/pos to outputs, calc_enable_out <= 1, entry valid <= 0.
REQ-031 Issue phase with alu_full_in high or no ready entry: calc_enable_out <= 0, data outputs hold.
REQ-032 Latency: dispatch with both operands ready -> calc_enable_out high after next issue-phase edge (minimum 1 accept + 1 issue cycle).
REQ-033 At most one issue per issue-phase cycle; at most one dispatch per accept-phase cycle.
REQ-034 Dispatch and CDB inputs SHALL be ignored during issue phase.
REQ-035 clear_flag_in high (either phase, chip_enable high): all valid <= 0, calc_enable_out <= 0; dispatch, CDB and issue that cycle ignored.
REQ-036 Entry freed in issue phase is available to dispatch in the immediately following accept phase.

Reset
REQ-037 rst high at an edge: chip_enable <= 0, all valid <= 0, calc_enable_out <= 0, calc_code_out/lhs_out/rhs_out/pos_in_iq_out <= 0; full_out therefore 0.
REQ-038 rst overrides clear, dispatch and issue in the same cycle; mid-operation reset discards all entries.

Verification
REQ-039 Dispatch code=0, lhs=5, rhs=7 ready, pos=3, alu_full_in=0 -> next issue phase: calc_enable_out=1, code=0, lhs_out=5, rhs_out=7, pos_in_iq_out=3; deasserted after following accept edge.
REQ-040 Dispatch code=1, lhs tag=2 unready, rhs=4 ready; later CDB idx=2 value=0x10 -> issue lhs_out=0x10, rhs_out=4; no issue before CDB.
REQ-041 Fill all 8 entries with unready operands -> full_out=1; ninth dispatch dropped; one CDB wakeup + issue -> full_out=0.
REQ-042 Two ready entries at idx 0 and 5, alu_full_in=1 for 3 issue phases -> no issue; release -> entry 0 issues first, entry 5 next issue phase.
REQ-043 Dispatch with lhs tag=6 unready while CDB idx=6 value=0xABCD same cycle -> entry ready, issues lhs_out=0xABCD.
REQ-044 4 valid entries, clear_flag_in pulse -> full_out=0, no calc_enable_out ever for those entries; rst mid-run -> all outputs 0.
